// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus sequencer: FSM states, default
// timing constants and command classification.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_DONE
  } lcd_state_t;

  localparam int unsigned LCD_T_SETUP = 2;
  localparam int unsigned LCD_T_PULSE = 12;
  localparam int unsigned LCD_T_HOLD  = 2;
  localparam int unsigned LCD_T_EXEC  = 2000;
  localparam int unsigned LCD_T_LONG  = 82000;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (!rs) && (data[7:2] == 6'b0);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Down-counter shared by every phase and execution wait of the sequencer.
// Loading N-1 gives a phase of N cycles ending on the zero flag.
module lcd_delay_counter #(
  parameter int unsigned CW = 18
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_value,
  output logic          zero
);

  logic [CW-1:0] count;

  // Load takes priority; counting stops at zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780-style LCD bus sequencer: one byte per Valid/Ready handshake with
// setup, E strobe, hold and command execution wait.
// Optional macro LCD_NIBBLE_MODE_EN selects the 4-bit bus (two strobes per
// byte, or one when Single is set).
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = LCD_T_SETUP,
  parameter int unsigned T_PULSE = LCD_T_PULSE,
  parameter int unsigned T_HOLD  = LCD_T_HOLD,
  parameter int unsigned T_EXEC  = LCD_T_EXEC,
  parameter int unsigned T_LONG  = LCD_T_LONG
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Valid,
  input  logic       Rs,
  input  logic [7:0] Data,
  input  logic       Single,
  output logic       Ready,
  output logic       Done,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB
);

  localparam int unsigned M1    = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned M2    = (M1 > T_HOLD) ? M1 : T_HOLD;
  localparam int unsigned M3    = (M2 > T_EXEC) ? M2 : T_EXEC;
  localparam int unsigned T_MAX = (M3 > T_LONG) ? M3 : T_LONG;
  localparam int unsigned CW    = $clog2(T_MAX) + 1;

  lcd_state_t    state, state_next;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          load;
  logic [CW-1:0] load_value;
  logic [CW-1:0] wait_value;
  logic          zero;
  logic          accept;
  logic          nib_set;

`ifdef LCD_NIBBLE_MODE_EN
  logic          single_q;
  logic          nib_q;
`else
  logic          unused_single;
  assign unused_single = Single;
`endif

  assign Ready  = (state == ST_IDLE) && !Reset;
  assign accept = Valid && Ready;

  lcd_delay_counter #(.CW(CW)) u_delay (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (load),
    .en         (state != ST_IDLE),
    .load_value (load_value),
    .zero       (zero)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch; it drives the bus directly so the bus holds its last value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rs_q   <= 1'b0;
      data_q <= '0;
`ifdef LCD_NIBBLE_MODE_EN
      single_q <= 1'b0;
      nib_q    <= 1'b0;
`endif
    end else if (accept) begin
      rs_q   <= Rs;
      data_q <= Data;
`ifdef LCD_NIBBLE_MODE_EN
      single_q <= Single;
      nib_q    <= 1'b0;
`endif
    end else if (nib_set) begin
`ifdef LCD_NIBBLE_MODE_EN
      nib_q <= 1'b1;
`endif
    end
  end

  // Execution wait selection; a single-nibble write always uses the normal wait.
  always_comb begin
    wait_value = CW'(T_EXEC - 1);
`ifdef LCD_NIBBLE_MODE_EN
    if (!single_q && is_long_cmd(rs_q, data_q)) begin
      wait_value = CW'(T_LONG - 1);
    end
`else
    if (is_long_cmd(rs_q, data_q)) begin
      wait_value = CW'(T_LONG - 1);
    end
`endif
  end

  // Next-state logic; each phase loads the counter for the following phase.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_value = '0;
    nib_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Valid) begin
          state_next = ST_SETUP;
          load       = 1'b1;
          load_value = CW'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (zero) begin
          state_next = ST_PULSE;
          load       = 1'b1;
          load_value = CW'(T_PULSE - 1);
        end
      end
      ST_PULSE: begin
        if (zero) begin
          state_next = ST_HOLD;
          load       = 1'b1;
          load_value = CW'(T_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (zero) begin
          state_next = ST_EXEC;
          load       = 1'b1;
          load_value = wait_value;
`ifdef LCD_NIBBLE_MODE_EN
          // High nibble sent: loop back through SETUP for the low nibble.
          if (!nib_q && !single_q) begin
            state_next = ST_SETUP;
            load_value = CW'(T_SETUP - 1);
            nib_set    = 1'b1;
          end
`endif
        end
      end
      ST_EXEC: begin
        if (zero) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign Done   = (state == ST_DONE);
  assign LCD_E  = (state == ST_PULSE);
  assign LCD_RW = 1'b0;
  assign LCD_RS = rs_q;
`ifdef LCD_NIBBLE_MODE_EN
  assign LCD_DB = {(nib_q ? data_q[3:0] : data_q[7:4]), 4'h0};
`else
  assign LCD_DB = data_q;
`endif

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Self-checking bench for lcd_bus_sequencer: a timeline model predicts every
// output from the accept cycle, plus literal latency checks.
module tb_lcd_bus_sequencer;

  localparam int TS = 1;
  localparam int TP = 3;
  localparam int TH = 1;
  localparam int TE = 5;
  localparam int TL = 20;
  localparam int P  = TS + TP + TH;

`ifdef LCD_NIBBLE_MODE_EN
  localparam int LAT_CHAR = 15;
  localparam int LAT_CLR  = 30;
`else
  localparam int LAT_CHAR = 10;
  localparam int LAT_CLR  = 25;
`endif
  localparam int LAT_SINGLE = 10;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Valid = 1'b0;
  logic       Rs = 1'b0;
  logic [7:0] Data = 8'h00;
  logic       Single = 1'b0;
  logic       Ready, Done, LCD_RS, LCD_RW, LCD_E;
  logic [7:0] LCD_DB;

  lcd_bus_sequencer #(
    .T_SETUP (TS),
    .T_PULSE (TP),
    .T_HOLD  (TH),
    .T_EXEC  (TE),
    .T_LONG  (TL)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Valid  (Valid),
    .Rs     (Rs),
    .Data   (Data),
    .Single (Single),
    .Ready  (Ready),
    .Done   (Done),
    .LCD_RS (LCD_RS),
    .LCD_RW (LCD_RW),
    .LCD_E  (LCD_E),
    .LCD_DB (LCD_DB)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model state: one transaction described by its accept cycle and length.
  int         cyc = 0;
  bit         m_active = 1'b0;
  bit         m_two = 1'b0;
  int         m_t0 = 0;
  int         m_L = 0;
  logic       m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       last_rs = 1'b0;
  logic [7:0] last_db = 8'h00;
  int         n_acc = 0;
  int         acc_t0 = 0;
  int         n_done = 0;
  int         done_cyc = 0;
  int         ready_cyc = 0;
  bit         prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] db_at(input int d);
`ifdef LCD_NIBBLE_MODE_EN
    if (m_two && d >= P) return {m_data[3:0], 4'h0};
    return {m_data[7:4], 4'h0};
`else
    return (d >= 0) ? m_data : 8'h00;
`endif
  endfunction

  function automatic logic e_at(input int d);
    return ((d >= TS) && (d < TS + TP)) ||
           (m_two && (d >= P + TS) && (d < P + TS + TP));
  endfunction

  // Per-cycle check at the negedge, then advance the model across the next edge.
  initial begin
    forever begin
      int d;
      logic exp_e, exp_done, exp_ready, exp_rs;
      logic [7:0] exp_db;
      bit long_cmd;
      int w;
      @(negedge Clk);
      if (m_active) begin
        d         = cyc - m_t0;
        exp_ready = 1'b0;
        exp_done  = (d == m_L);
        exp_e     = e_at(d);
        exp_rs    = m_rs;
        exp_db    = db_at(d);
      end else begin
        exp_ready = !Reset;
        exp_done  = 1'b0;
        exp_e     = 1'b0;
        exp_rs    = last_rs;
        exp_db    = last_db;
      end
      chk("ready", Ready, exp_ready);
      chk("done", Done, exp_done);
      chk("lcd_e", LCD_E, exp_e);
      chk("lcd_rs", LCD_RS, exp_rs);
      chk("lcd_db", LCD_DB, exp_db);
      chk("lcd_rw", LCD_RW, 1'b0);
      if (Done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (prev_done && Ready) ready_cyc = cyc;
      prev_done = Done;

      cyc++;
      if (Reset) begin
        m_active = 1'b0;
        last_rs  = 1'b0;
        last_db  = 8'h00;
      end else if (!m_active && Valid) begin
        m_active = 1'b1;
        m_t0     = cyc;
        m_rs     = Rs;
        m_data   = Data;
        long_cmd = (Rs == 1'b0) && (Data < 8'd4);
`ifdef LCD_NIBBLE_MODE_EN
        m_two = !Single;
        w = Single ? TE : (long_cmd ? TL : TE);
`else
        m_two = 1'b0;
        w = long_cmd ? TL : TE;
`endif
        m_L    = (m_two ? 2 * P : P) + w;
        n_acc++;
        acc_t0 = cyc;
      end else if (m_active && (cyc - m_t0 == m_L + 1)) begin
        m_active = 1'b0;
        last_rs  = m_rs;
        last_db  = db_at(m_L);
      end
    end
  end

  task automatic wait_accept(output int t0);
    int start;
    bit got;
    start = n_acc;
    got = 1'b0;
    t0 = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge Clk);
      if (n_acc != start) begin
        got = 1'b1;
        t0 = acc_t0;
        break;
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic rs, input logic [7:0] data, input logic single, output int t0);
    @(posedge Clk); #1;
    Valid = 1'b1; Rs = rs; Data = data; Single = single;
    wait_accept(t0);
    #1 Valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int t0, input int lat);
    int start;
    bit got;
    start = n_done;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge Clk);
      if (n_done != start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    else chk(name, done_cyc - t0, lat);
    @(posedge Clk); @(posedge Clk);
    chk("ready_after_done", ready_cyc - t0, lat + 1);
  endtask

  initial begin
    int t0, t1, nd;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (6) @(posedge Clk);
    chk("idle_ready", Ready, 1'b1);
    chk("idle_db", LCD_DB, 8'h00);
    chk("idle_no_done", n_done, 0);

    issue(1'b1, 8'h41, 1'b0, t0);
    wait_done("lat_char", t0, LAT_CHAR);
    issue(1'b0, 8'h01, 1'b0, t0);
    wait_done("lat_clear", t0, LAT_CLR);
    issue(1'b0, 8'h04, 1'b0, t0);
    wait_done("lat_cmd04", t0, LAT_CHAR);

    // Valid held across two requests; data changes while busy.
    @(posedge Clk); #1;
    Valid = 1'b1; Rs = 1'b1; Data = 8'h48; Single = 1'b0;
    wait_accept(t0);
    #1 Data = 8'h49;
    wait_accept(t1);
    #1 Valid = 1'b0;
    chk("b2b_spacing", t1 - t0, LAT_CHAR + 2);
    wait_done("lat_b2b", t1, LAT_CHAR);

    // Reset during the E pulse.
    issue(1'b1, 8'h55, 1'b0, t0);
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    chk("rst_e_low", LCD_E, 1'b0);
    nd = n_done;
    repeat (40) @(posedge Clk);
    chk("rst_no_done", n_done - nd, 0);
    issue(1'b1, 8'h42, 1'b0, t0);
    wait_done("lat_after_rst", t0, LAT_CHAR);

    issue(1'b0, 8'h30, 1'b1, t0);
    wait_done("lat_single", t0, LAT_SINGLE);

    // Random traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge Clk); #1;
      Valid  = ($urandom_range(3) != 0);
      Rs     = $urandom_range(1);
      Data   = ($urandom_range(3) == 0) ? 8'($urandom_range(3)) : 8'($urandom);
      Single = $urandom_range(1);
      Reset  = ($urandom_range(299) == 0);
    end
    #1 Valid = 1'b0; Reset = 1'b0;
    repeat (50) @(posedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
